// File: rtl/aes_job_sequencer.sv
// Job sequencer for the Custom_AES core: runs chained (optionally duplicated)
// encryptions of one key/plaintext job, with a per-encryption watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; job inputs latched on accept
// ISSUE   | waiting for the core to be idle (aes_bsy=0)
// KD      | aes_kdrdy pulse to the core; watchdog cleared
// WAIT    | waiting for aes_dvld; watchdog running
// EVAL    | redundancy compare, chain-count bookkeeping
// DONE    | done pulse, then back to IDLE
module aes_job_sequencer #(
   parameter int ITER_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              start,
   input  logic [127:0]      job_key,
   input  logic [127:0]      job_data,
   input  logic [ITER_W-1:0] job_iter,
   input  logic              job_redund,
   output logic              busy,
   output logic              done,
   output logic [127:0]      result,
   output logic              fault,
   output logic              timeout,
   output logic              aes_en,
   output logic [127:0]      aes_kin,
   output logic [127:0]      aes_din,
   output logic              aes_kdrdy,
   input  logic [127:0]      aes_dout,
   input  logic              aes_dvld,
   input  logic              aes_bsy
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_KD, S_WAIT, S_EVAL, S_DONE
   } state_t;

   state_t            state_q;
   logic              busy_q, done_q, fault_q, timeout_q, en_q, kdrdy_q;
   logic [127:0]      result_q, kin_q, din_q, cap_q, ref_q;
   logic [ITER_W-1:0] rem_q;
   logic              redund_q;
   logic              pass_q;      // 0 = first pass, 1 = redundant second pass
   logic [WD_W-1:0]   wdog_q;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
         timeout_q <= 1'b0;
         en_q      <= 1'b0;
         kdrdy_q   <= 1'b0;
         result_q  <= '0;
         kin_q     <= '0;
         din_q     <= '0;
         cap_q     <= '0;
         ref_q     <= '0;
         rem_q     <= '0;
         redund_q  <= 1'b0;
         pass_q    <= 1'b0;
         wdog_q    <= '0;
      end else begin
         en_q    <= 1'b1;
         kdrdy_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  kin_q     <= job_key;
                  din_q     <= job_data;
                  rem_q     <= (job_iter == '0) ? ITER_W'(1) : job_iter;
                  redund_q  <= job_redund;
                  pass_q    <= 1'b0;
                  fault_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!aes_bsy) begin
                  kdrdy_q <= 1'b1;
                  state_q <= S_KD;
               end
            end
            S_KD: begin
               wdog_q  <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // a result arriving in the expiry cycle still counts
               if (aes_dvld) begin
                  cap_q   <= aes_dout;
                  state_q <= S_EVAL;
               end else if (wdog_q == WD_MAX) begin
                  timeout_q <= 1'b1;
                  result_q  <= '0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            S_EVAL: begin
               if (redund_q && !pass_q) begin
                  ref_q   <= cap_q;
                  pass_q  <= 1'b1;
                  state_q <= S_ISSUE;
               end else if (redund_q && (cap_q != ref_q)) begin
                  fault_q  <= 1'b1;
                  result_q <= cap_q;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == ITER_W'(1)) begin
                     result_q <= cap_q;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     din_q   <= cap_q;
                     pass_q  <= 1'b0;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign fault     = fault_q;
   assign timeout   = timeout_q;
   assign aes_en    = en_q;
   assign aes_kin   = kin_q;
   assign aes_din   = din_q;
   assign aes_kdrdy = kdrdy_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with a behavioural AES-128 core model
// whose output latency, silence and bit-flip can be steered per job.
module tb_aes_job_sequencer;
   localparam int ITER_W  = 8;
   localparam int TIMEOUT = 64;
   localparam logic [127:0] K   = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] D   = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] EXP = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic              RSTn, start, job_redund;
   logic [127:0]      job_key, job_data;
   logic [ITER_W-1:0] job_iter;
   logic              busy, done, fault, timeout, aes_en, aes_kdrdy;
   logic [127:0]      result, aes_kin, aes_din, aes_dout;
   logic              aes_dvld, aes_bsy;

   aes_job_sequencer #(.ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RSTn(RSTn), .start(start), .job_key(job_key), .job_data(job_data),
      .job_iter(job_iter), .job_redund(job_redund), .busy(busy), .done(done),
      .result(result), .fault(fault), .timeout(timeout), .aes_en(aes_en),
      .aes_kin(aes_kin), .aes_din(aes_din), .aes_kdrdy(aes_kdrdy),
      .aes_dout(aes_dout), .aes_dvld(aes_dvld), .aes_bsy(aes_bsy)
   );

   int n_pass = 0;
   int n_chk  = 0;

   // ---------------- AES-128 reference ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   function automatic void build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] xb, inv, r1, r2, r3, r4;
         xb  = x[7:0];
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            logic [7:0] yb;
            yb = y[7:0];
            if (gmul(xb, yb) == 8'h01) inv = yb;
         end
         r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
         sbox_t[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      end
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [7:0]   rcon;
      logic [7:0]   s [16];
      logic [7:0]   n [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) n[r+4*c] = s[r+4*((c+r)%4)];
         s = n;
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- core model ----------------
   int           lat     = 1;   // dvld arrives lat cycles after the KD cycle; 0 = never
   int           flip_at = -1;  // pulse number whose result gets bit 0 flipped
   int           kd_total = 0;
   int           kd_consec = 0;
   logic [127:0] din_log [int];
   logic [127:0] mdl_val;
   int           mdl_cnt;
   bit           mdl_pend = 0;
   bit           prev_kd  = 0;

   initial begin
      aes_dvld = 1'b0;
      aes_dout = '0;
      forever begin
         @(posedge CLK);
         if (!RSTn) begin
            mdl_pend = 0;
         end else if (aes_kdrdy === 1'b1) begin
            kd_total++;
            din_log[kd_total] = aes_din;
            mdl_val = aes_enc(aes_kin, aes_din);
            if (kd_total == flip_at) mdl_val[0] = ~mdl_val[0];
            mdl_pend = (lat != 0);
            mdl_cnt  = lat;
         end
         if (aes_kdrdy === 1'b1 && prev_kd) kd_consec++;
         prev_kd = (aes_kdrdy === 1'b1);
         #1;
         aes_dvld = 1'b0;
         if (mdl_pend) begin
            if (mdl_cnt == 1) begin
               aes_dvld = 1'b1;
               aes_dout = mdl_val;
               mdl_pend = 0;
            end else begin
               mdl_cnt--;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_job(input logic [127:0] k, input logic [127:0] d,
                            input logic [ITER_W-1:0] it, input logic red);
      job_key = k; job_data = d; job_iter = it; job_redund = red;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int c = 0;
      while (done !== 1'b1 && c < max) begin
         tick();
         c++;
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [127:0] c1, c2, c3, x;
   int           base, dseen;

   initial begin
      build_sbox();
      RSTn = 1'b0; start = 1'b0; job_key = '0; job_data = '0; job_iter = '0;
      job_redund = 1'b0; aes_bsy = 1'b0;
      c1 = aes_enc(K, D); c2 = aes_enc(K, c1); c3 = aes_enc(K, c2);

      repeat (3) tick();
      chk("rst_ctrl", {busy, done, fault, timeout, aes_en, aes_kdrdy}, 0);
      chk("rst_result", result, 0);
      chk("rst_kin", aes_kin, 0);
      chk("rst_din", aes_din, 0);
      RSTn = 1'b1;
      tick();
      chk("en_after_rst", aes_en, 1);

      // single encryption, FIPS-197 vector
      lat = 3; base = kd_total;
      start_job(K, D, 1, 0);
      chk("single_busy", busy, 1);
      chk("single_kd_early", aes_kdrdy, 0);
      tick();
      chk("single_kd_T2", aes_kdrdy, 1);
      chk("single_kin", aes_kin, K);
      chk("single_din", aes_din, D);
      wait_done(200);
      chk("single_done", done, 1);
      chk("single_result", result, EXP);
      chk("single_flags", {fault, timeout}, 0);
      tick();
      chk("single_done_1cyc", done, 0);
      chk("single_busy_idle", busy, 0);
      chk("single_kd_cnt", kd_total - base, 1);

      // chain of 3, with start pulses during the job that must be ignored
      lat = 2; base = kd_total;
      start_job(K, D, 3, 0);
      job_data = '0; job_iter = 1; start = 1'b1;
      tick(); tick();
      start = 1'b0;
      wait_done(300);
      chk("chain_result", result, c3);
      chk("chain_kd_cnt", kd_total - base, 3);
      chk("chain_din2", din_log[base+2], c1);
      chk("chain_din3", din_log[base+3], c2);

      // iter=0 behaves like 1
      tick(); base = kd_total;
      start_job(K, D, 0, 0);
      wait_done(200);
      chk("iter0_result", result, EXP);
      chk("iter0_kd_cnt", kd_total - base, 1);

      // redundant, no fault
      tick(); base = kd_total;
      start_job(K, D, 2, 1);
      wait_done(400);
      chk("red_result", result, c2);
      chk("red_fault", fault, 0);
      chk("red_kd_cnt", kd_total - base, 4);
      chk("red_passB_din", din_log[base+2], D);
      chk("red_chain_din", din_log[base+3], c1);

      // redundant, second pass corrupted
      tick(); base = kd_total; flip_at = base + 2;
      start_job(K, D, 2, 1);
      wait_done(400);
      chk("flt_done", done, 1);
      chk("flt_fault", fault, 1);
      chk("flt_result", result, c1 ^ 128'h1);
      chk("flt_kd_cnt", kd_total - base, 2);
      flip_at = -1;
      tick();
      start_job(K, D, 1, 0);
      chk("flt_cleared", fault, 0);
      wait_done(200);

      // watchdog: core stays silent
      tick(); lat = 0;
      start_job(K, D, 1, 0);
      tick();
      chk("wd_kd", aes_kdrdy, 1);
      repeat (TIMEOUT) tick();
      chk("wd_not_yet", {timeout, done}, 0);
      tick();
      chk("wd_timeout", {timeout, done}, 2'b11);
      chk("wd_result", result, 0);
      tick();
      chk("wd_sticky", {timeout, busy}, 2'b10);

      // dvld lands in the expiry cycle
      lat = TIMEOUT;
      start_job(K, D, 1, 0);
      chk("wd_cleared", timeout, 0);
      wait_done(200);
      chk("wd_edge_done", done, 1);
      chk("wd_edge_timeout", timeout, 0);
      chk("wd_edge_result", result, EXP);

      // core busy for 5 cycles delays kdrdy by 5
      tick(); lat = 1; aes_bsy = 1'b1;
      start_job(K, D, 1, 0);
      repeat (4) tick();
      chk("bsy_hold", aes_kdrdy, 0);
      tick();
      aes_bsy = 1'b0;
      chk("bsy_still_issue", aes_kdrdy, 0);
      tick();
      chk("bsy_kd_T7", aes_kdrdy, 1);
      wait_done(100);
      chk("bsy_result", result, EXP);

      // reset while waiting on the core
      tick(); lat = 0;
      start_job(K, D, 1, 0);
      repeat (3) tick();
      RSTn = 1'b0;
      tick();
      chk("midrst_ctrl", {busy, done, fault, timeout, aes_en, aes_kdrdy}, 0);
      chk("midrst_result", result, 0);
      chk("midrst_kin_din", {aes_kin, aes_din} == 256'h0, 1);
      RSTn = 1'b1;
      dseen = 0;
      repeat (10) begin
         tick();
         if (done === 1'b1) dseen++;
      end
      chk("midrst_no_done", dseen, 0);
      chk("midrst_idle", {busy, aes_en}, 2'b01);

      // all-ones chain count: 255 encryptions
      lat = 1; base = kd_total;
      start_job(K, D, '1, 0);
      wait_done(3000);
      x = D;
      for (int i = 0; i < 255; i++) x = aes_enc(K, x);
      chk("max_result", result, x);
      chk("max_kd_cnt", kd_total - base, 255);
      chk("kd_never_back2back", kd_consec, 0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
